// File: rtl/lab2_proc_imem_drop_pkg.sv
// Shared constants, the instruction-memory response message and helpers for the
// imem response drop unit.
package lab2_proc_imem_drop_pkg;

  localparam int unsigned MAX_INFLIGHT_DEFAULT = 2;
  localparam int unsigned DEPTH_DEFAULT        = 2;
  localparam int unsigned INFLIGHT_W           = $clog2(MAX_INFLIGHT_DEFAULT + 1);

  typedef logic [INFLIGHT_W-1:0] inflight_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lab2_proc_imem_drop_fifo.sv
// Normal (non-bypass) p_depth x 32b queue with a synchronous flush; enq is only
// presented when not full, so a full queue never sees enq and deq together.
module lab2_proc_imem_drop_fifo
  import lab2_proc_imem_drop_pkg::*;
#(
  parameter int unsigned p_depth = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        enq_val,
  input  logic [31:0] enq_data,
  input  logic        deq_rdy,
  output logic        empty,
  output logic        full,
  output logic [31:0] deq_data
);

  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);

  logic [31:0]   mem_q [p_depth];
  logic [31:0]   mem_d [p_depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_enq, do_deq;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign deq_data = mem_q[rd_ptr_q];
  assign do_enq   = enq_val & ~full;
  assign do_deq   = deq_rdy & ~empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_enq) - CW'(do_deq);
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_deq) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset because the head entry drives resp_out_data, which must read 0 out of reset.
      for (int i = 0; i < int'(p_depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(p_depth); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/lab2_proc_imem_resp_drop_unit.sv
// Drops imem responses belonging to squashed fetches and queues the survivors for D.
// Define LAB2_PROC_IMEM_DROP_STATS_EN to add saturating num_dropped/num_squashed counters.
module lab2_proc_imem_resp_drop_unit
  import lab2_proc_imem_drop_pkg::*;
#(
  parameter int unsigned p_max_inflight = MAX_INFLIGHT_DEFAULT,
  parameter int unsigned p_depth        = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic         squash,
  input  logic         resp_in_val,
  output logic         resp_in_rdy,
  input  mem_resp_4B_t resp_in_msg,
  output logic         resp_out_val,
  input  logic         resp_out_rdy,
  output logic [31:0]  resp_out_data,
  output logic [$clog2(p_max_inflight+1)-1:0] inflight
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  ,
  output logic [31:0]  num_dropped,
  output logic [31:0]  num_squashed
`endif
);

  localparam int unsigned IW = $clog2(p_max_inflight + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(p_max_inflight);

  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_cnt_q, drop_cnt_d;
  logic          drop_active, req_fire, resp_fire, discard, enq;
  logic          fifo_empty, fifo_full;
  logic          unused_msg_bits;

  assign unused_msg_bits = ^{resp_in_msg.typ, resp_in_msg.opaque, resp_in_msg.test, resp_in_msg.len};

  assign drop_active  = (drop_cnt_q != '0);
  assign resp_in_rdy  = drop_active | squash | ~fifo_full;
  assign resp_fire    = resp_in_val & resp_in_rdy;
  // A response retiring this cycle frees a slot for the request in the same cycle.
  assign req_rdy      = (inflight_q < MAX_CNT) | resp_fire;
  assign req_fire     = req_val & req_rdy;
  assign discard      = resp_fire & (drop_active | squash);
  assign enq          = resp_fire & ~discard;
  assign resp_out_val = ~fifo_empty & ~squash;
  assign inflight     = inflight_q;

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !resp_fire) begin
      inflight_d = inflight_q + IW'(1);
    end else if (resp_fire && !req_fire && inflight_q != '0) begin
      inflight_d = inflight_q - IW'(1);
    end

    drop_cnt_d = drop_cnt_q;
    if (squash) begin
      // Everything older than the redirect is dropped, minus a response retiring now.
      drop_cnt_d = (resp_fire && inflight_q != '0) ? inflight_q - IW'(1) : inflight_q;
    end else if (discard) begin
      drop_cnt_d = drop_cnt_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  lab2_proc_imem_drop_fifo #(
    .p_depth (p_depth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (squash),
    .enq_val  (enq),
    .enq_data (resp_in_msg.data),
    .deq_rdy  (resp_out_rdy & ~squash),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .deq_data (resp_out_data)
  );

`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  logic [31:0] num_dropped_q, num_dropped_d;
  logic [31:0] num_squashed_q, num_squashed_d;

  always_comb begin
    num_dropped_d  = discard ? sat_inc32(num_dropped_q) : num_dropped_q;
    num_squashed_d = squash ? sat_inc32(num_squashed_q) : num_squashed_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_dropped_q  <= '0;
      num_squashed_q <= '0;
    end else begin
      num_dropped_q  <= num_dropped_d;
      num_squashed_q <= num_squashed_d;
    end
  end

  assign num_dropped  = num_dropped_q;
  assign num_squashed = num_squashed_q;
`endif

  // A response with nothing outstanding means the memory side broke the protocol.
  resp_without_req_a : assert property (@(posedge clk) disable iff (!reset)
    !(resp_fire && inflight_q == '0));

endmodule

// File: tb/tb_lab2_proc_imem_resp_drop_unit.sv
// Self-checking bench for lab2_proc_imem_resp_drop_unit: vector table plus hand
// sequences, with a scoreboard queue for delivered instruction words.
module tb_lab2_proc_imem_resp_drop_unit;
  import lab2_proc_imem_drop_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_val = 1'b0;
  logic         squash = 1'b0;
  logic         resp_in_val = 1'b0;
  logic         resp_out_rdy = 1'b0;
  mem_resp_4B_t resp_in_msg = '0;
  logic         req_rdy, resp_in_rdy, resp_out_val;
  logic [31:0]  resp_out_data;
  inflight_t    inflight;
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  logic [31:0]  num_dropped, num_squashed;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        rq, sq, rv;
    logic [31:0] d;
    logic        ordy, push;
    logic        e_req_rdy, e_in_rdy, e_out_val;
    logic [1:0]  e_infl;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  lab2_proc_imem_resp_drop_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .squash        (squash),
    .resp_in_val   (resp_in_val),
    .resp_in_rdy   (resp_in_rdy),
    .resp_in_msg   (resp_in_msg),
    .resp_out_val  (resp_out_val),
    .resp_out_rdy  (resp_out_rdy),
    .resp_out_data (resp_out_data),
    .inflight      (inflight)
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    ,
    .num_dropped   (num_dropped),
    .num_squashed  (num_squashed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted output word must match the oldest expected survivor.
  always @(negedge clk) begin
    if (reset && resp_out_val && resp_out_rdy) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%08h expected no output", resp_out_data);
      end else begin
        check("sb_data", resp_out_data, sb.pop_front());
      end
    end
  end

  task automatic add(input logic rq, sq, rv, input logic [31:0] d, input logic ordy, push,
                     input logic e_req_rdy, e_in_rdy, e_out_val, input logic [1:0] e_infl,
                     input string nm);
    vec_t v;
    v.rq = rq; v.sq = sq; v.rv = rv; v.d = d; v.ordy = ordy; v.push = push;
    v.e_req_rdy = e_req_rdy; v.e_in_rdy = e_in_rdy; v.e_out_val = e_out_val;
    v.e_infl = e_infl; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge: drive one cycle, check handshakes mid-cycle,
  // then check the registered inflight count after the edge.
  task automatic step(input logic rq, sq, rv, input logic [31:0] d, input logic ordy, push,
                      input logic e_req_rdy, e_in_rdy, e_out_val, input logic [1:0] e_infl,
                      input string nm);
    req_val          = rq;
    squash           = sq;
    resp_in_val      = rv;
    resp_in_msg      = '0;
    resp_in_msg.data = d;
    resp_out_rdy     = ordy;
    if (push) sb.push_back(d);
    @(negedge clk);
    check({nm, ".req_rdy"}, 32'(req_rdy), 32'(e_req_rdy));
    check({nm, ".resp_in_rdy"}, 32'(resp_in_rdy), 32'(e_in_rdy));
    check({nm, ".resp_out_val"}, 32'(resp_out_val), 32'(e_out_val));
    @(posedge clk);
    #1;
    check({nm, ".inflight"}, 32'(inflight), 32'(e_infl));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".req_rdy"}, 32'(req_rdy), 32'd1);
    check({nm, ".resp_in_rdy"}, 32'(resp_in_rdy), 32'd1);
    check({nm, ".resp_out_val"}, 32'(resp_out_val), 32'd0);
    check({nm, ".resp_out_data"}, resp_out_data, 32'd0);
    check({nm, ".inflight"}, 32'(inflight), 32'd0);
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    check({nm, ".num_dropped"}, num_dropped, 32'd0);
    check({nm, ".num_squashed"}, num_squashed, 32'd0);
`endif
  endtask

  task automatic async_reset_pulse(input string nm);
    req_val = 1'b0; squash = 1'b0; resp_in_val = 1'b0; resp_out_rdy = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_outputs(nm);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //  rq sq rv data          ordy push | req_rdy in_rdy out_val inflight
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s1_req");
    add(0, 0, 1, 32'h00000013, 1, 1,  1, 1, 0, 2'd0, "s1_resp");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 1, 2'd0, "s1_out");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s1_idle");
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s2_req0");
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd2, "s2_req1");
    add(0, 1, 0, 32'h0,        1, 0,  0, 1, 0, 2'd2, "s2_squash");
    add(0, 0, 1, 32'hAAAA0001, 1, 0,  1, 1, 0, 2'd1, "s2_drop0");
    add(0, 0, 1, 32'hAAAA0002, 1, 0,  1, 1, 0, 2'd0, "s2_drop1");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s2_idle");
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s3_req");
    add(1, 1, 0, 32'h0,        1, 0,  1, 1, 0, 2'd2, "s3_squash_req");
    add(0, 0, 1, 32'hDEAD0000, 1, 0,  1, 1, 0, 2'd1, "s3_drop");
    add(0, 0, 1, 32'h00000067, 1, 1,  1, 1, 0, 2'd0, "s3_resp");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 1, 2'd0, "s3_out");
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s5_req0");
    add(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd2, "s5_req1");
    add(1, 0, 0, 32'h0,        1, 0,  0, 1, 0, 2'd2, "s5_at_limit");
    add(1, 0, 1, 32'h00000055, 1, 1,  1, 1, 0, 2'd2, "s5_resp_req");
    add(0, 0, 1, 32'h00000066, 1, 1,  1, 1, 1, 2'd1, "s5_resp1");
    add(0, 0, 1, 32'h00000077, 1, 1,  1, 1, 1, 2'd0, "s5_resp2");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 1, 2'd0, "s5_out");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s5_idle");
    add(1, 0, 0, 32'h0,        0, 0,  1, 1, 0, 2'd1, "s7_req");
    add(0, 0, 1, 32'h00000011, 0, 0,  1, 1, 0, 2'd0, "s7_resp");
    add(0, 0, 0, 32'h0,        0, 0,  1, 1, 1, 2'd0, "s7_hold");
    add(0, 1, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s7_squash_flush");
    add(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s7_after_flush");

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rq, vecs[i].sq, vecs[i].rv, vecs[i].d, vecs[i].ordy, vecs[i].push,
           vecs[i].e_req_rdy, vecs[i].e_in_rdy, vecs[i].e_out_val, vecs[i].e_infl, vecs[i].nm);
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
      if (vecs[i].nm == "s2_idle") begin
        check("s2.num_dropped", num_dropped, 32'd2);
        check("s2.num_squashed", num_squashed, 32'd1);
      end
`endif
    end
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    check("tbl.num_dropped", num_dropped, 32'd3);
    check("tbl.num_squashed", num_squashed, 32'd3);
`endif

    // FIFO fills while D stalls; the third response waits and order is kept.
    step(1, 0, 0, 32'h0,        0, 0,  1, 1, 0, 2'd1, "s4_req0");
    step(1, 0, 0, 32'h0,        0, 0,  1, 1, 0, 2'd2, "s4_req1");
    step(1, 0, 1, 32'h4A000001, 0, 1,  1, 1, 0, 2'd2, "s4_resp_a");
    step(1, 0, 1, 32'h4B000002, 0, 1,  1, 1, 1, 2'd2, "s4_resp_b");
    step(0, 0, 1, 32'h4C000003, 0, 0,  0, 0, 1, 2'd2, "s4_full0");
    check("s4_hold0", resp_out_data, 32'h4A000001);
    step(0, 0, 1, 32'h4C000003, 0, 0,  0, 0, 1, 2'd2, "s4_full1");
    check("s4_hold1", resp_out_data, 32'h4A000001);
    step(0, 0, 1, 32'h4C000003, 1, 0,  0, 0, 1, 2'd2, "s4_drain_a");
    step(0, 0, 1, 32'h4C000003, 1, 1,  1, 1, 1, 2'd1, "s4_resp_c");
    step(0, 0, 1, 32'h4D000004, 1, 1,  1, 1, 1, 2'd0, "s4_resp_d");
    step(0, 0, 0, 32'h0,        1, 0,  1, 1, 1, 2'd0, "s4_out_d");
    step(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s4_idle");

    // Reset while the FIFO holds a word and requests are outstanding.
    step(1, 0, 0, 32'h0,        0, 0,  1, 1, 0, 2'd1, "s6a_req0");
    step(1, 0, 0, 32'h0,        0, 0,  1, 1, 0, 2'd2, "s6a_req1");
    step(0, 0, 1, 32'h000000F0, 0, 0,  1, 1, 0, 2'd1, "s6a_resp");
    check("s6a_pre.resp_out_val", 32'(resp_out_val), 32'd1);
    check("s6a_pre.resp_out_data", resp_out_data, 32'h000000F0);
    async_reset_pulse("s6a_reset");

    // Reset mid-drop: a fresh fetch afterwards must be delivered, not dropped.
    step(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s6b_req0");
    step(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd2, "s6b_req1");
    step(0, 1, 0, 32'h0,        1, 0,  0, 1, 0, 2'd2, "s6b_squash");
    step(0, 0, 1, 32'hBAD00001, 1, 0,  1, 1, 0, 2'd1, "s6b_drop");
    async_reset_pulse("s6b_reset");
    step(1, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd1, "s6c_req");
    step(0, 0, 1, 32'h00001234, 1, 1,  1, 1, 0, 2'd0, "s6c_resp");
    step(0, 0, 0, 32'h0,        1, 0,  1, 1, 1, 2'd0, "s6c_out");
    step(0, 0, 0, 32'h0,        1, 0,  1, 1, 0, 2'd0, "s6c_idle");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
